// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_MAX_WAIT   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } arbState_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, data and memory bus signals seen by the unified memory arbiter.
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic [WIDTH-1:0]      if_rdata;
  logic                  if_valid;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0]      dm_wdata;
  logic [WIDTH-1:0]      dm_rdata;
  logic                  dm_valid;
  logic                  stall_f;
  logic                  stall_m;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_ready;
  logic [WIDTH-1:0]      mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid, stall_f, stall_m,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // Pipeline stages plus memory side
  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid, stall_f, stall_m,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating count of data grants issued while fetch waits; sat forces a fetch grant.
module arb_starve_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_W'(MAX_WAIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sat = (cnt == CNT_W'(MAX_WAIT));
endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch and data requests onto one memory bus; data wins unless fetch has starved.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                        clk,
  input  logic                        reset,
  unified_mem_arbiter_if.slave        bus
);
  arbState_t             state;
  logic                  flushPend;
  logic                  starveSat;
  logic                  ifElig;
  logic                  dmElig;
  logic                  grantIf;
  logic                  grantDm;
  logic [ADDR_WIDTH-1:0] grantAddr;
  logic [WIDTH-1:0]      grantWdata;

  // A requester in its completion cycle is masked so it is not granted twice.
  assign ifElig  = bus.if_req & ~bus.if_valid;
  assign dmElig  = bus.dm_req & ~bus.dm_valid;
  assign grantDm = (state == IDLE) & dmElig & ~(ifElig & starveSat);
  assign grantIf = (state == IDLE) & ifElig & (~dmElig | starveSat);

  assign grantAddr  = grantIf ? bus.if_addr : bus.dm_addr;
  assign grantWdata = bus.dm_wdata;

  assign bus.stall_f = bus.if_req & ~bus.if_valid;
  assign bus.stall_m = bus.dm_req & ~bus.dm_valid;

  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (grantDm & bus.if_req),
    .clr   (grantIf),
    .sat   (starveSat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      flushPend     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_valid  <= 1'b0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.dm_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grantDm) begin
            state         <= BUSY_DM;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= grantAddr;
            bus.mem_wdata <= grantWdata;
          end else if (grantIf) begin
            state        <= BUSY_IF;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= grantAddr;
          end
        end
        BUSY_IF: begin
          // A flushed fetch still finishes on the bus but its data is dropped.
          if (bus.mem_ready) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            flushPend   <= 1'b0;
            if (!flushPend && !bus.if_flush) begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end else if (bus.if_flush) begin
            flushPend <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (bus.mem_ready) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.dm_valid <= 1'b1;
            if (!bus.mem_we) begin
              bus.dm_rdata <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   nTotal;
  int   nBad;

  unified_mem_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

  unified_mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTotal++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] expAddr [8];
    logic [31:0] seenAddr [8];
    int          grants;
    logic        prevReq;

    nTotal = 0;
    nBad   = 0;
    reset  = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_flush = 1'b0;
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
    bus.mem_ready = 1'b0;  bus.mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_if_valid", 64'(bus.if_valid), 64'd0);
    check("rst_dm_rdata", 64'(bus.dm_rdata), 64'd0);
    tick();

    // Fetch only, memory ready in the first busy cycle
    bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0010;
    bus.mem_ready = 1'b1;  bus.mem_rdata = 32'h0050_0093;
    #1;
    check("f_stall_pre", 64'(bus.stall_f), 64'd1);
    tick();
    check("f_mem_req", 64'(bus.mem_req), 64'd1);
    check("f_mem_addr", 64'(bus.mem_addr), 64'h10);
    check("f_mem_we", 64'(bus.mem_we), 64'd0);
    check("f_valid_early", 64'(bus.if_valid), 64'd0);
    check("f_stall_busy", 64'(bus.stall_f), 64'd1);
    tick();
    check("f_valid", 64'(bus.if_valid), 64'd1);
    check("f_rdata", 64'(bus.if_rdata), 64'h0050_0093);
    check("f_stall_done", 64'(bus.stall_f), 64'd0);
    check("f_mem_req_drop", 64'(bus.mem_req), 64'd0);
    bus.if_req = 1'b0;  bus.mem_ready = 1'b0;
    tick();
    check("f_valid_pulse", 64'(bus.if_valid), 64'd0);

    // Store, then load back the same address
    bus.dm_req = 1'b1;  bus.dm_we = 1'b1;  bus.dm_addr = 32'h40;  bus.dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("st_mem_req", 64'(bus.mem_req), 64'd1);
    check("st_mem_we", 64'(bus.mem_we), 64'd1);
    check("st_mem_addr", 64'(bus.mem_addr), 64'h40);
    check("st_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    bus.mem_ready = 1'b1;  bus.mem_rdata = 32'h1234_5678;
    tick();
    check("st_valid", 64'(bus.dm_valid), 64'd1);
    check("st_rdata_hold", 64'(bus.dm_rdata), 64'd0);
    bus.dm_we = 1'b0;  bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("ld_bubble", 64'(bus.mem_req), 64'd0);
    tick();
    check("ld_mem_req", 64'(bus.mem_req), 64'd1);
    check("ld_mem_we", 64'(bus.mem_we), 64'd0);
    tick();
    check("ld_valid", 64'(bus.dm_valid), 64'd1);
    check("ld_rdata", 64'(bus.dm_rdata), 64'hDEAD_BEEF);
    bus.dm_req = 1'b0;  bus.mem_ready = 1'b0;
    tick();

    // Contention; fetch drops its request only while a data completion is shown
    expAddr = '{32'h200, 32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h200, 32'h100};
    bus.if_req = 1'b1;  bus.if_addr = 32'h100;
    bus.dm_req = 1'b1;  bus.dm_we = 1'b0;  bus.dm_addr = 32'h200;
    bus.mem_ready = 1'b1;  bus.mem_rdata = 32'h0000_1111;
    grants  = 0;
    prevReq = bus.mem_req;
    for (int cyc = 0; cyc < 60 && grants < 8; cyc++) begin
      tick();
      if (bus.mem_req && !prevReq) begin
        seenAddr[grants] = bus.mem_addr;
        grants++;
      end
      prevReq    = bus.mem_req;
      bus.if_req = ~bus.dm_valid;
    end
    check("cont_grants", 64'(grants), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < grants) check($sformatf("cont_grant%0d", i), 64'(seenAddr[i]), 64'(expAddr[i]));
    end
    bus.dm_req = 1'b0;
    bus.if_req = 1'b1;
    tick();
    check("cont_if_valid", 64'(bus.if_valid), 64'd1);
    bus.if_req = 1'b0;  bus.mem_ready = 1'b0;
    tick();
    check("cont_if_rdata", 64'(bus.if_rdata), 64'h0000_1111);

    // Memory wait states on a store
    bus.dm_req = 1'b1;  bus.dm_we = 1'b1;  bus.dm_addr = 32'h80;  bus.dm_wdata = 32'hCAFE_F00D;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ws_req%0d", i), 64'(bus.mem_req), 64'd1);
      check($sformatf("ws_addr%0d", i), 64'(bus.mem_addr), 64'h80);
      check($sformatf("ws_wdata%0d", i), 64'(bus.mem_wdata), 64'hCAFE_F00D);
      check($sformatf("ws_valid%0d", i), 64'(bus.dm_valid), 64'd0);
      check($sformatf("ws_stall%0d", i), 64'(bus.stall_m), 64'd1);
      tick();
    end
    bus.mem_ready = 1'b1;
    tick();
    check("ws_valid", 64'(bus.dm_valid), 64'd1);
    check("ws_stall_done", 64'(bus.stall_m), 64'd0);
    bus.dm_req = 1'b0;  bus.mem_ready = 1'b0;
    tick();

    // Flush during a fetch, then refetch at the new address
    bus.if_req = 1'b1;  bus.if_addr = 32'h300;  bus.mem_rdata = 32'h0000_0BAD;
    tick();
    check("fl_mem_addr", 64'(bus.mem_addr), 64'h300);
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0;  bus.if_addr = 32'h304;
    check("fl_addr_stable", 64'(bus.mem_addr), 64'h300);
    bus.mem_ready = 1'b1;
    tick();
    check("fl_no_valid", 64'(bus.if_valid), 64'd0);
    check("fl_rdata_hold", 64'(bus.if_rdata), 64'h0000_1111);
    check("fl_req_drop", 64'(bus.mem_req), 64'd0);
    bus.mem_rdata = 32'h00A0_0113;
    tick();
    check("fl_refetch_addr", 64'(bus.mem_addr), 64'h304);
    tick();
    check("fl_refetch_valid", 64'(bus.if_valid), 64'd1);
    check("fl_refetch_rdata", 64'(bus.if_rdata), 64'h00A0_0113);
    bus.if_req = 1'b0;  bus.mem_ready = 1'b0;
    tick();

    // Reset in the middle of a data transfer
    bus.dm_req = 1'b1;  bus.dm_we = 1'b0;  bus.dm_addr = 32'h400;
    tick();
    check("rm_mem_req", 64'(bus.mem_req), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rm_req_async", 64'(bus.mem_req), 64'd0);
    check("rm_addr_async", 64'(bus.mem_addr), 64'd0);
    bus.dm_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("rm_no_valid", 64'(bus.dm_valid), 64'd0);
    check("rm_rdata_clr", 64'(bus.dm_rdata), 64'd0);
    bus.dm_req = 1'b1;  bus.mem_ready = 1'b1;  bus.mem_rdata = 32'h0000_55AA;
    tick();
    check("rm_regrant", 64'(bus.mem_req), 64'd1);
    tick();
    check("rm_valid", 64'(bus.dm_valid), 64'd1);
    check("rm_rdata", 64'(bus.dm_rdata), 64'h0000_55AA);
    bus.dm_req = 1'b0;  bus.mem_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined core.
- Serialises both requesters onto one request/ready memory bus and returns read data to each.
- Data side has priority; a starvation counter guarantees forward progress for fetch.
- Sits between the fetch/memory stages and the memory, replacing the separate instruction and data memory ports.

Parameters:
WIDTH, 32, data width of all read/write data buses
ADDR_WIDTH, 32, address width
MAX_WAIT, 3, consecutive data grants issued while fetch is pending before fetch is forced through (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch request; held high with stable if_addr until if_valid
if_addr  input  ADDR_WIDTH  fetch address
if_flush  input  1  cancel outstanding fetch (taken branch/jump)
if_rdata  output  WIDTH  fetched instruction, valid when if_valid
if_valid  output  1  one-cycle completion pulse for fetch
dm_req  input  1  data request; held with stable fields until dm_valid
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_WIDTH  data address
dm_wdata  input  WIDTH  store data
dm_rdata  output  WIDTH  load data, valid when dm_valid
dm_valid  output  1  one-cycle completion pulse (load data or store ack)
stall_f  output  1  if_req & ~if_valid (combinational)
stall_m  output  1  dm_req & ~dm_valid (combinational)
mem_req  output  1  memory bus request
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address (registered)
mem_wdata  output  WIDTH  memory write data (registered)
mem_ready  input  1  memory completes the current transfer this cycle
mem_rdata  input  WIDTH  memory read data, sampled when mem_ready

Behaviour:
- Reset values (asynchronous): state IDLE; mem_req, mem_we, if_valid, dm_valid = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starve_cnt = 0; flush_pend = 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE, arbitration on the clock edge:
  - A requester is eligible only if its req=1 and its valid is not high in this cycle. This masks the completion cycle so a finished request is not re-granted.
  - Only dm eligible -> BUSY_DM.
  - Only if eligible -> BUSY_IF.
  - Both eligible: starve_cnt == MAX_WAIT -> BUSY_IF; otherwise -> BUSY_DM.
  - Neither eligible -> stay in IDLE.
- Grant edge: mem_addr, mem_we, mem_wdata are latched from the winner (mem_we = 0 for fetch). mem_req = 1 from the next cycle.
- BUSY_x: mem_req held at 1 with all bus fields stable until a cycle with mem_ready = 1.
  - On that edge: state -> IDLE, mem_req -> 0, and the x_valid pulse is registered high for exactly one cycle.
  - Load/fetch: x_rdata <= mem_rdata.
  - Store: dm_rdata holds its previous value.
- Latency: minimum 3 cycles from req to valid (grant, bus cycle with mem_ready = 1, valid). There is one idle bubble between back-to-back transfers.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) on each DM grant made while if_req = 1.
  - Clears on every IF grant.
  - Otherwise holds.
- Flush (if_flush = 1):
  - In IDLE with no fetch granted: no effect on the arbiter; the requester simply changes if_addr.
  - In BUSY_IF: the bus transfer still completes and is not aborted. flush_pend is set, the matching if_valid is suppressed, and if_rdata is not updated. flush_pend clears on that completion.
  - If if_flush coincides with the completion edge: the pulse is suppressed.
  - In BUSY_DM: ignored.
- mem_ready while in IDLE is ignored.
- Reset asserted mid-transfer: the transfer is abandoned immediately (mem_req drops asynchronously) and no valid is issued. Requesters re-request after reset.
- stall_f/stall_m are purely combinational and never registered.

Decomposition:
- Shared package: state encoding (IDLE = 2'b00, BUSY_IF = 2'b01, BUSY_DM = 2'b10) and the default MAX_WAIT.
- One natural sub-module: arb_starve_counter (saturating up-counter with clear, width clog2(MAX_WAIT+1), inputs inc/clr, output sat).
- Everything else lives in unified_mem_arbiter.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010; memory returns 0x0050_0093 with mem_ready in the first BUSY cycle -> mem_addr=0x10, mem_we=0; if_valid pulses 3 cycles after req with if_rdata=0x0050_0093; stall_f=1 until then.
- Store then load: dm_we=1, dm_addr=0x40, dm_wdata=0xDEAD_BEEF -> mem_we=1, mem_wdata=0xDEADBEEF, dm_valid pulse with dm_rdata unchanged; then a load at 0x40 with mem_rdata=0xDEADBEEF -> dm_rdata=0xDEADBEEF.
- Contention: if_req and dm_req held continuously, MAX_WAIT=3 -> grant order DM, DM, DM, IF, DM, DM, DM, IF...; starve_cnt clears after each IF grant.
- Memory wait states: mem_ready low for 5 cycles in BUSY_DM -> mem_req, mem_addr, mem_wdata stable for all 5 cycles; dm_valid only after the mem_ready cycle.
- Flush: assert if_flush during BUSY_IF -> the bus transfer completes, no if_valid, if_rdata unchanged; the next fetch at the new address is granted normally.
- Reset mid-transfer: assert reset during BUSY_DM with mem_ready=0 -> mem_req=0 immediately, state IDLE, no dm_valid after reset release until a fresh request completes.
